imem_responder: RTL and testbench

- Instruction-memory responder: the far end of the IF stage's instruction fetch interface.
- Accepts one fetch request per PC, returns the instruction word after a programmable number of wait states, and raises busy so the pipeline holds PC and the IF/ID register.
- Includes a loader write port so benches and boot logic can fill the program before fetching.
- Sits between IF and a word-addressed instruction store.

---
 rtl/mips_pkg.sv | 19 +
 rtl/imem_array.sv | 25 ++
 rtl/imem_responder.sv | 144 ++++++++++++++
 tb/tb_imem_responder.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch path: responder states, the
// bubble/NOP encoding and the byte-address to word-index helper.
package mips_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } imem_state_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam int          IMEM_CNT_W = 4;

  // Full 30-bit word index; callers slice the low bits for the array and use
  // the high bits for range checking.
  function automatic logic [29:0] word_index(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

endpackage

// File: rtl/imem_array.sv
// Word-addressed instruction store: synchronous write, combinational read.
module imem_array #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [31:0]           i_wdata,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [2**DEPTH_LOG2];

  // NOTE: the storage has no reset; contents are defined only after the
  // loader writes them, which keeps this mappable onto RAM primitives.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_responder.sv
// Far end of the IF-stage fetch interface: accepts a PC, returns the word after
// WAIT_CYCLES wait states, holds the pipeline via busy, and arbitrates a loader port.
module imem_responder
  import mips_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 8,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] NOP_WORD    = mips_pkg::NOP_WORD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [31:0]           addr,
  input  logic                  flush,
  output logic [31:0]           inst,
  output logic                  valid,
  output logic                  busy,
  output logic                  addr_err,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [31:0]           ld_data,
  output logic                  ld_ack
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_cfg_check
    $error("imem_responder: WAIT_CYCLES must be in 0..15");
  end

  localparam logic [IMEM_CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? '0 : IMEM_CNT_W'(WAIT_CYCLES - 1);

  imem_state_t           r_state, w_state_nxt;
  logic [IMEM_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [DEPTH_LOG2-1:0] r_idx, w_idx_nxt;
  logic [31:0]           r_inst, w_inst_nxt;
  logic                  r_valid, w_valid_nxt;
  logic                  r_err, w_err_nxt;
  logic                  r_ld_ack;
  logic                  w_busy;

  logic [29:0]           w_word;
  logic                  w_legal;
  logic                  w_ld_we;
  logic [DEPTH_LOG2-1:0] w_rd_idx;
  logic [31:0]           w_rdata;

  // Upper word-index bits must be zero for the PC to fall inside the store.
  assign w_word   = word_index(addr);
  assign w_legal  = (addr[1:0] == 2'b00) && (w_word[29:DEPTH_LOG2] == '0);
  assign w_ld_we  = (r_state == IDLE) && !req && ld_en;
  assign w_rd_idx = (r_state == WAIT) ? r_idx : w_word[DEPTH_LOG2-1:0];

  imem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk    (clk),
    .i_we   (w_ld_we),
    .i_waddr(ld_addr),
    .i_wdata(ld_data),
    .i_raddr(w_rd_idx),
    .o_rdata(w_rdata)
  );

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_inst_nxt  = r_inst;
    w_valid_nxt = 1'b0;
    w_err_nxt   = r_err;
    w_busy      = 1'b0;

    case (r_state)
      IDLE: begin
        if (req && !flush) begin
          if (!w_legal) begin
            w_valid_nxt = 1'b1;
            w_err_nxt   = 1'b1;
            w_inst_nxt  = NOP_WORD;
          end else begin
            w_busy    = 1'b1;
            w_idx_nxt = w_word[DEPTH_LOG2-1:0];
            if (WAIT_CYCLES == 0) begin
              w_valid_nxt = 1'b1;
              w_err_nxt   = 1'b0;
              w_inst_nxt  = w_rdata;
            end else begin
              w_state_nxt = WAIT;
              w_cnt_nxt   = CNT_INIT;
            end
          end
        end
      end

      WAIT: begin
        w_busy = 1'b1;
        if (flush) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_valid_nxt = 1'b1;
          w_err_nxt   = 1'b0;
          w_inst_nxt  = w_rdata;
          w_state_nxt = IDLE;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all registers
  // sample the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_inst   <= NOP_WORD;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_ld_ack <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_inst   <= w_inst_nxt;
      r_valid  <= w_valid_nxt;
      r_err    <= w_err_nxt;
      r_ld_ack <= w_ld_we;
    end
  end

  assign inst     = r_inst;
  assign valid    = r_valid;
  assign addr_err = r_err;
  assign busy     = w_busy;
  assign ld_ack   = r_ld_ack;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: two instances (2 and 0 wait states) share stimulus;
// a cycle-level model predicts every output and directed literals pin the model.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        flush = 1'b0;
  logic        ld_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] ld_data = '0;
  logic [7:0]  ld_addr = '0;

  logic [31:0] inst_o [2];
  logic        valid_o [2];
  logic        busy_o [2];
  logic        err_o [2];
  logic        ack_o [2];

  int checks = 0;
  int errors = 0;

  logic [31:0] prog [4] = '{32'h2008_0005, 32'h2009_0003, 32'h0109_5020, 32'h0800_0000};

  always #5 clk = ~clk;

  imem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .flush(flush),
    .inst(inst_o[0]), .valid(valid_o[0]), .busy(busy_o[0]), .addr_err(err_o[0]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ack_o[0])
  );

  imem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .flush(flush),
    .inst(inst_o[1]), .valid(valid_o[1]), .busy(busy_o[1]), .addr_err(err_o[1]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ack_o[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A fetch accepted in cycle c is due at the edge closing cycle c+W; it is
  // dropped if flush is seen at any edge before or on that one.
  logic [31:0] m_mem [2][256];
  bit          m_pend [2] = '{0, 0};
  int          m_due [2];
  int          m_idx [2];
  logic [31:0] m_inst [2] = '{32'h0, 32'h0};
  bit          m_valid [2] = '{0, 0};
  bit          m_err [2] = '{0, 0};
  bit          m_ack [2] = '{0, 0};
  int          cyc = 0;

  function automatic int wait_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < 32'd1024);
  endfunction

  task automatic model_edge(input int k, input int c);
    m_valid[k] = 0;
    m_ack[k]   = 0;
    if (m_pend[k]) begin
      if (flush) begin
        m_pend[k] = 0;
      end else if (c == m_due[k]) begin
        m_pend[k]  = 0;
        m_valid[k] = 1;
        m_err[k]   = 0;
        m_inst[k]  = m_mem[k][m_idx[k]];
      end
    end else if (req && !flush) begin
      if (!legal(addr)) begin
        m_valid[k] = 1;
        m_err[k]   = 1;
        m_inst[k]  = 32'h0;
      end else if (wait_of(k) == 0) begin
        m_valid[k] = 1;
        m_err[k]   = 0;
        m_inst[k]  = m_mem[k][addr / 4];
      end else begin
        m_pend[k] = 1;
        m_due[k]  = c + wait_of(k);
        m_idx[k]  = int'(addr / 4);
      end
    end else if (!req && ld_en) begin
      m_mem[k][ld_addr] = ld_data;
      m_ack[k] = 1;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        m_pend[k]  = 0;
        m_inst[k]  = 32'h0;
        m_valid[k] = 0;
        m_err[k]   = 0;
        m_ack[k]   = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) model_edge(k, cyc);
      cyc++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic exp_busy;
      exp_busy = m_pend[k] || (req && !flush && legal(addr));
      check($sformatf("model_inst[%0d]", k),  inst_o[k],  m_inst[k]);
      check($sformatf("model_valid[%0d]", k), valid_o[k], m_valid[k]);
      check($sformatf("model_busy[%0d]", k),  busy_o[k],  exp_busy);
      check($sformatf("model_ack[%0d]", k),   ack_o[k],   m_ack[k]);
      if (m_valid[k]) check($sformatf("model_err[%0d]", k), err_o[k], m_err[k]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Steps at least one cycle, then until the 2-wait instance pulses valid.
  task automatic wait_valid0(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!valid_o[0] && n < 20);
    if (!valid_o[0]) check("valid0_timeout", 32'd0, 32'd1);
  endtask

  task automatic fetch0(input logic [31:0] a, output int n);
    req  = 1'b1;
    addr = a;
    tick();
    req = 1'b0;
    n = 1;
    while (!valid_o[0] && n < 20) begin
      tick();
      n++;
    end
    if (!valid_o[0]) check("fetch0_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    int vcount;
    logic [31:0] bad_addrs [2];
    bad_addrs = '{32'h6, 32'h400};

    // Reset values
    #8;
    for (int k = 0; k < 2; k++) begin
      check("rst_inst", inst_o[k], 32'h0);
      check("rst_valid", valid_o[k], 1'b0);
      check("rst_busy", busy_o[k], 1'b0);
    end
    #4 rst = 1'b1;
    tick();

    // Program load
    for (int i = 0; i < 4; i++) begin
      ld_en   = 1'b1;
      ld_addr = 8'(i);
      ld_data = prog[i];
      tick();
      check("ld_ack_w2", ack_o[0], 1'b1);
      check("ld_ack_w0", ack_o[1], 1'b1);
    end
    ld_en = 1'b0;
    tick();

    // Latency
    req  = 1'b1;
    addr = 32'h4;
    @(negedge clk);
    check("lat_busy_n_w2", busy_o[0], 1'b1);
    check("lat_busy_n_w0", busy_o[1], 1'b1);
    tick();
    req = 1'b0;
    check("lat_valid_n1_w0", valid_o[1], 1'b1);
    check("lat_inst_n1_w0", inst_o[1], 32'h2009_0003);
    check("lat_valid_n1_w2", valid_o[0], 1'b0);
    @(negedge clk);
    check("lat_busy_n1_w2", busy_o[0], 1'b1);
    check("lat_busy_n1_w0", busy_o[1], 1'b0);
    tick();
    check("lat_valid_n2_w2", valid_o[0], 1'b0);
    @(negedge clk);
    check("lat_busy_n2_w2", busy_o[0], 1'b1);
    tick();
    check("lat_valid_n3_w2", valid_o[0], 1'b1);
    check("lat_inst_n3_w2", inst_o[0], 32'h2009_0003);
    check("lat_err_n3_w2", err_o[0], 1'b0);
    @(negedge clk);
    check("lat_busy_n3_w2", busy_o[0], 1'b0);
    tick();

    // Back-to-back with address stepping on each valid
    req  = 1'b1;
    addr = 32'h0;
    for (int k = 0; k < 3; k++) begin
      wait_valid0(n);
      check("b2b_gap", 32'(n), 32'd3);
      check("b2b_inst", inst_o[0], prog[k]);
      if (k < 2) addr = 32'((k + 1) * 4);
      else       req = 1'b0;
    end
    tick();

    // Illegal addresses: misaligned and out of range
    for (int i = 0; i < 2; i++) begin
      req  = 1'b1;
      addr = bad_addrs[i];
      @(negedge clk);
      check("err_busy_w2", busy_o[0], 1'b0);
      check("err_busy_w0", busy_o[1], 1'b0);
      tick();
      req = 1'b0;
      check("err_valid_w2", valid_o[0], 1'b1);
      check("err_flag_w2", err_o[0], 1'b1);
      check("err_inst_w2", inst_o[0], 32'h0);
      check("err_valid_w0", valid_o[1], 1'b1);
      check("err_flag_w0", err_o[1], 1'b1);
      tick();
    end

    // Flush one cycle after acceptance
    req  = 1'b1;
    addr = 32'h8;
    tick();
    req   = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    check("flA_busy_n1", busy_o[0], 1'b1);
    tick();
    flush = 1'b0;
    check("flA_valid_n2", valid_o[0], 1'b0);
    @(negedge clk);
    check("flA_busy_n2", busy_o[0], 1'b0);
    vcount = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (valid_o[0]) vcount++;
    end
    check("flA_no_valid", 32'(vcount), 32'd0);

    // Flush on the completing cycle
    req  = 1'b1;
    addr = 32'h8;
    tick();
    req = 1'b0;
    tick();
    flush = 1'b1;
    @(negedge clk);
    check("flB_busy_n2", busy_o[0], 1'b1);
    tick();
    flush = 1'b0;
    check("flB_valid_n3", valid_o[0], 1'b0);
    @(negedge clk);
    check("flB_busy_n3", busy_o[0], 1'b0);
    vcount = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (valid_o[0]) vcount++;
    end
    check("flB_no_valid", 32'(vcount), 32'd0);

    fetch0(32'hC, n);
    check("post_flush_lat", 32'(n), 32'd3);
    check("post_flush_inst", inst_o[0], 32'h0800_0000);
    tick();

    // Loader blocked while a fetch is in flight
    req  = 1'b1;
    addr = 32'h0;
    tick();
    req     = 1'b0;
    ld_en   = 1'b1;
    ld_addr = 8'd0;
    ld_data = 32'hDEAD_BEEF;
    tick();
    check("ldblk_ack_n2", ack_o[0], 1'b0);
    tick();
    ld_en = 1'b0;
    check("ldblk_ack_n3", ack_o[0], 1'b0);
    check("ldblk_valid_n3", valid_o[0], 1'b1);
    check("ldblk_inst_n3", inst_o[0], prog[0]);
    tick();
    fetch0(32'h0, n);
    check("ldblk_readback", inst_o[0], prog[0]);
    tick();

    // Reset mid-fetch
    req  = 1'b1;
    addr = 32'h4;
    tick();
    req = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rstmid_inst", inst_o[0], 32'h0);
    check("rstmid_valid", valid_o[0], 1'b0);
    check("rstmid_busy", busy_o[0], 1'b0);
    check("rstmid_err", err_o[0], 1'b0);
    check("rstmid_ack", ack_o[0], 1'b0);
    tick();
    #3 rst = 1'b1;
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (valid_o[0]) vcount++;
    end
    check("rstmid_no_valid", 32'(vcount), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
